sisc_ctrl_v2: RTL and testbench

Parametrised multi-cycle control FSM for the SISC datapath. It is the successor to the first-generation ALU-only controller. It adds full instruction-class decode (load/store/branch/halt), a configurable memory-latency wait counter, branch resolution against the status register, and a sticky hardware halt state in place of a simulation stop. It sits between the IR/status register and the datapath: PC, register file, ALU, data memory and status register.

---
 rtl/sisc_ctrl_v2_if.sv | 42 ++++
 rtl/sisc_ctrl_v2.sv | 194 +++++++++++++++++++
 tb/tb_sisc_ctrl_v2.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sisc_ctrl_v2_if.sv
// Purpose: groups the IR/status inputs and the datapath control strobes of the SISC controller.
// Latency: none; pure wiring between the controller and the datapath side.
// Backpressure: none; the datapath must accept every control strobe in the cycle it is driven.
interface sisc_ctrl_v2_if #(
    parameter int OP_W   = 4,
    parameter int MM_W   = 4,
    parameter int STAT_W = 4
);
    // Instruction fields and flags presented to the controller
    logic [OP_W-1:0]   opcode;
    logic [MM_W-1:0]   mm;
    logic [STAT_W-1:0] stat;

    // Datapath control strobes
    logic              ir_load;
    logic              pc_write;
    logic              pc_sel;
    logic              br_sel;
    logic              pc_rst;
    logic [1:0]        alu_op;
    logic              rf_we;
    logic              wb_sel;
    logic              rb_sel;
    logic              dm_we;
    logic              stat_en;
    logic              halted;
    logic [3:0]        state;

    // Controller side
    modport master (
        input  opcode, mm, stat,
        output ir_load, pc_write, pc_sel, br_sel, pc_rst, alu_op,
               rf_we, wb_sel, rb_sel, dm_we, stat_en, halted, state
    );

    // Datapath / IR side
    modport slave (
        output opcode, mm, stat,
        input  ir_load, pc_write, pc_sel, br_sel, pc_rst, alu_op,
               rf_we, wb_sel, rb_sel, dm_we, stat_en, halted, state
    );
endinterface

// File: rtl/sisc_ctrl_v2.sv
// Purpose: multi-cycle SISC control FSM (fetch/decode/execute/mem/writeback, branch resolve, sticky halt).
// Latency: LOD/STR 4+MEM_LAT cycles, ALU/branch/NOOP 5, SWP 6 when CTRL_SWP_EN is defined (FETCH to FETCH).
// Backpressure: none; memory latency is absorbed by a fixed MEM wait count. Optional macro: CTRL_SWP_EN.
module sisc_ctrl_v2 #(
    parameter int OP_W    = 4,
    parameter int MM_W    = 4,
    parameter int STAT_W  = 4,   // must equal MM_W: branch condition is stat & mm
    parameter int MEM_LAT = 1,   // >= 1
    parameter int AM_IMM  = 8
) (
    input  logic          clk,
    input  logic          rst_f,
    sisc_ctrl_v2_if.master bus
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

`ifdef CTRL_SWP_EN
    localparam bit SWP_EN = 1'b1;
`else
    // SWP falls through as a NOOP; WB2 can never be entered.
    localparam bit SWP_EN = 1'b0;
`endif

    // Opcode values; 0 and 9..14 are NOOP and need no decode term.
    localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    typedef enum logic [3:0] {
        START0    = 4'd0,
        START1    = 4'd1,
        FETCH     = 4'd2,
        DECODE    = 4'd3,
        EXECUTE   = 4'd4,
        MEM       = 4'd5,
        WRITEBACK = 4'd6,
        WB2       = 4'd7,
        HALT      = 4'd8
    } state_t;

    // START0 encodes as zero so a zero power-up image lands there.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic is_lod, is_str, is_swp, is_alu, is_hlt;
    logic is_bra, is_brr, is_bne, is_bnr;
    logic is_mem, is_rel, cond_hit, br_taken;
    logic [1:0] ex_alu_op;

    logic       ir_load, pc_write, pc_sel, br_sel, pc_rst;
    logic [1:0] alu_op;
    logic       rf_we, wb_sel, rb_sel, dm_we, stat_en, halted;

    // Instruction class decode and branch resolution
    always_comb begin
        is_lod   = (bus.opcode == OP_LOD);
        is_str   = (bus.opcode == OP_STR);
        is_swp   = (bus.opcode == OP_SWP) && SWP_EN;
        is_alu   = (bus.opcode == OP_ALU);
        is_hlt   = (bus.opcode == OP_HLT);
        is_bra   = (bus.opcode == OP_BRA);
        is_brr   = (bus.opcode == OP_BRR);
        is_bne   = (bus.opcode == OP_BNE);
        is_bnr   = (bus.opcode == OP_BNR);
        is_mem   = is_lod | is_str;
        is_rel   = is_brr | is_bnr;
        cond_hit = |(bus.stat & bus.mm);
        br_taken = ((is_bra | is_brr) & cond_hit) | ((is_bne | is_bnr) & ~cond_hit);

        // ALU mode held through EXECUTE and MEM so the result is stable at WRITEBACK
        if (is_alu) begin
            ex_alu_op = (bus.mm == MM_W'(AM_IMM)) ? 2'b01 : 2'b00;
        end else if (is_mem) begin
            ex_alu_op = 2'b11;
        end else if (is_swp) begin
            ex_alu_op = 2'b00;
        end else begin
            ex_alu_op = 2'b10;
        end
    end

    // Memory wait counter: armed entering MEM, counts down to the access cycle
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == EXECUTE) begin
            cnt_d = is_mem ? CNT_W'(MEM_LAT - 1) : '0;
        end else if ((state_q == MEM) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State and counter registers; reset drops straight to START1
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= START1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control strobes from present state and IR fields
    always_comb begin
        state_d  = state_q;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        alu_op   = 2'b10;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        dm_we    = 1'b0;
        stat_en  = 1'b0;
        halted   = 1'b0;

        case (state_q)
            START0: begin
                pc_rst  = 1'b1;
                state_d = START1;
            end
            START1: begin
                pc_rst  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_rel;
                end
                state_d = is_hlt ? HALT : EXECUTE;
            end
            EXECUTE: begin
                alu_op  = ex_alu_op;
                state_d = MEM;
            end
            MEM: begin
                alu_op = ex_alu_op;
                // Store strobes only in the final wait cycle: one pulse per STR
                if (cnt_q == '0) begin
                    dm_we   = is_str;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we   = is_alu | is_lod | is_swp;
                wb_sel  = is_lod;
                stat_en = is_alu;
                state_d = is_swp ? WB2 : FETCH;
            end
            WB2: begin
                rf_we   = 1'b1;
                rb_sel  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = START1;
            end
        endcase
    end

    assign bus.ir_load  = ir_load;
    assign bus.pc_write = pc_write;
    assign bus.pc_sel   = pc_sel;
    assign bus.br_sel   = br_sel;
    assign bus.pc_rst   = pc_rst;
    assign bus.alu_op   = alu_op;
    assign bus.rf_we    = rf_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.rb_sel   = rb_sel;
    assign bus.dm_we    = dm_we;
    assign bus.stat_en  = stat_en;
    assign bus.halted   = halted;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_sisc_ctrl_v2.sv
// Purpose: self-checking bench for sisc_ctrl_v2 against an instruction-level reference model.
// Latency: every cycle of every instruction is compared (state and all control strobes).
// Backpressure: not applicable; stimulus is directed cases followed by random instructions.
module tb_sisc_ctrl_v2;

    localparam int MEM_LAT = 3;

`ifdef CTRL_SWP_EN
    localparam bit SWP_EN = 1'b1;
`else
    localparam bit SWP_EN = 1'b0;
`endif

    // Phase numbering used by the model (matches the published state codes)
    localparam int P_START1 = 1, P_FETCH = 2, P_DECODE = 3, P_EXEC = 4;
    localparam int P_MEM = 5, P_WB = 6, P_WB2 = 7, P_HALT = 8;

    logic clk = 1'b0;
    logic rst_f;

    always #5 clk = ~clk;

    sisc_ctrl_v2_if #(.OP_W(4), .MM_W(4), .STAT_W(4)) bus ();

    sisc_ctrl_v2 #(
        .OP_W(4), .MM_W(4), .STAT_W(4), .MEM_LAT(MEM_LAT), .AM_IMM(8)
    ) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] obs_vec;
    assign obs_vec = {bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.pc_rst,
                      bus.alu_op, bus.rf_we, bus.wb_sel, bus.rb_sel, bus.dm_we,
                      bus.stat_en, bus.halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected control vector for one phase of an instruction, from the instruction rules
    function automatic logic [12:0] exp_out(input int ph, input logic [3:0] op,
                                            input logic [3:0] mm, input logic [3:0] stat,
                                            input bit last_mem);
        bit ir = 0, pw = 0, ps = 0, bs = 0, pr = 0, rf = 0, wb = 0, rb = 0;
        bit dw = 0, se = 0, hl = 0;
        logic [1:0] al = 2'b10;
        bit memop  = (op == 4'd1) || (op == 4'd2);
        bit swp    = SWP_EN && (op == 4'd3);
        bit isbr   = (op >= 4'd4) && (op <= 4'd7);
        bit hit    = ((stat & mm) != 4'd0);
        bit taken  = (op <= 4'd5) ? hit : !hit;
        case (ph)
            P_START1: pr = 1;
            P_FETCH: begin ir = 1; pw = 1; end
            P_DECODE: if (isbr && taken) begin
                pw = 1; ps = 1; bs = (op == 4'd5) || (op == 4'd7);
            end
            P_EXEC, P_MEM: begin
                if (op == 4'd8)  al = (mm == 4'd8) ? 2'b01 : 2'b00;
                else if (memop)  al = 2'b11;
                else if (swp)    al = 2'b00;
                if (ph == P_MEM && op == 4'd2 && last_mem) dw = 1;
            end
            P_WB: begin
                if (op == 4'd8) begin rf = 1; se = 1; end
                if (op == 4'd1) begin rf = 1; wb = 1; end
                if (swp)        rf = 1;
            end
            P_WB2: begin rf = 1; rb = 1; end
            P_HALT: hl = 1;
            default: ;
        endcase
        return {ir, pw, ps, bs, pr, al, rf, wb, rb, dw, se, hl};
    endfunction

    // Compare one cycle at the falling edge, then advance to just after the next rising edge
    task automatic step(input int ph, input logic [3:0] op, input logic [3:0] mm,
                        input logic [3:0] stat, input bit last_mem);
        @(negedge clk);
        check($sformatf("state op=%0d ph=%0d", op, ph), 32'(bus.state), 32'(ph));
        check($sformatf("outs op=%0d ph=%0d", op, ph), 32'(obs_vec),
              32'(exp_out(ph, op, mm, stat, last_mem)));
        @(posedge clk);
        #1;
    endtask

    // Release reset and confirm arrival in FETCH
    task automatic release_reset(input string tag);
        rst_f = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " fetch after reset"}, 32'(bus.state), 32'(P_FETCH));
    endtask

    // Run one instruction from FETCH to the next FETCH (HLT: 20 halt cycles then async reset)
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat);
        int  ph[$];
        bit  lm[$];
        int  n_mem;
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = stat;
        ph.push_back(P_FETCH);  lm.push_back(0);
        ph.push_back(P_DECODE); lm.push_back(0);
        if (op == 4'd15) begin
            for (int i = 0; i < 20; i++) begin ph.push_back(P_HALT); lm.push_back(0); end
        end else begin
            ph.push_back(P_EXEC); lm.push_back(0);
            n_mem = ((op == 4'd1) || (op == 4'd2)) ? MEM_LAT : 1;
            for (int i = 0; i < n_mem; i++) begin ph.push_back(P_MEM); lm.push_back(i == n_mem - 1); end
            ph.push_back(P_WB); lm.push_back(0);
            if (SWP_EN && op == 4'd3) begin ph.push_back(P_WB2); lm.push_back(0); end
        end
        for (int k = 0; k < ph.size(); k++) step(ph[k], op, mm, stat, lm[k]);
        if (op == 4'd15) begin
            // Reset must take effect mid-cycle, with no clock edge
            #1 rst_f = 1'b0;
            #1;
            check("halt async reset state", 32'(bus.state), 32'(P_START1));
            check("halt async reset outs", 32'(obs_vec),
                  32'(exp_out(P_START1, op, mm, stat, 0)));
            @(posedge clk);
            #1;
            release_reset("halt");
        end else begin
            check($sformatf("period end op=%0d", op), 32'(bus.state), 32'(P_FETCH));
        end
    endtask

    // STR interrupted by reset in its second MEM cycle: the store must never strobe
    task automatic store_reset_mid_mem(input logic [3:0] mm, input logic [3:0] stat);
        bus.opcode = 4'd2;
        bus.mm     = mm;
        bus.stat   = stat;
        step(P_FETCH, 4'd2, mm, stat, 0);
        step(P_DECODE, 4'd2, mm, stat, 0);
        step(P_EXEC, 4'd2, mm, stat, 0);
        step(P_MEM, 4'd2, mm, stat, 0);
        check("midmem second mem", 32'(bus.state), 32'(P_MEM));
        rst_f = 1'b0;
        #1;
        check("midmem async state", 32'(bus.state), 32'(P_START1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midmem dm_we", 32'(bus.dm_we), 32'd0);
            check("midmem held state", 32'(bus.state), 32'(P_START1));
        end
        @(posedge clk);
        #1;
        release_reset("midmem");
    endtask

    logic [3:0] r_op, r_mm, r_st;

    initial begin
        rst_f      = 1'b0;
        bus.opcode = 4'd0;
        bus.mm     = 4'd0;
        bus.stat   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(bus.state), 32'(P_START1));
        check("reset outs", 32'(obs_vec), 32'(exp_out(P_START1, 4'd0, 4'd0, 4'd0, 0)));
        check("reset wait", 32'(bus.halted), 32'd0);
        release_reset("init");

        // Directed cases
        run_instr(4'd8, 4'd0, 4'd0);      // ALU reg-reg
        run_instr(4'd8, 4'd8, 4'd3);      // ALU immediate
        run_instr(4'd2, 4'd5, 4'd0);      // STR, MEM_LAT waits
        run_instr(4'd1, 4'd0, 4'd0);      // LOD
        run_instr(4'd6, 4'd1, 4'd0);      // BNE taken
        run_instr(4'd6, 4'd1, 4'd1);      // BNE not taken
        run_instr(4'd5, 4'd2, 4'd2);      // BRR taken, relative
        run_instr(4'd4, 4'd4, 4'd2);      // BRA not taken
        run_instr(4'd7, 4'd0, 4'd15);     // BNR with empty mask: taken
        run_instr(4'd3, 4'd0, 4'd0);      // SWP
        run_instr(4'd11, 4'd8, 4'd8);     // reserved code as NOOP
        run_instr(4'd15, 4'd0, 4'd0);     // HLT
        store_reset_mid_mem(4'd0, 4'd0);

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_mm = 4'($urandom_range(0, 15));
            r_st = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_mm = 4'd8;
            run_instr(r_op, r_mm, r_st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
